ps2_keycode_receiver: RTL and testbench

PS2_KEYCODE_RECEIVER -- requirements
Module: ps2_keycode_receiver

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_frame_rx.sv | 143 ++++++++++++++
 rtl/ps2_keycode_receiver.sv | 89 ++++++++
 tb/tb_ps2_keycode_receiver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam int unsigned DEF_FILTER_LEN     = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 20000;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, clock glitch filter, frame FSM and inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       error_o
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;

  logic fall;
  logic bit_in;
  logic timeout;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};

    // Filtered level flips only after FILTER_LEN consecutive differing samples.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    fall   = filt_q & ~filt_d;
    bit_in = data_sync_q[1];

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    timer_d   = timer_q;
    valid_o   = 1'b0;
    error_o   = 1'b0;

    timeout = (state_q != ST_IDLE) && !fall && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    if (state_q != ST_IDLE) begin
      timer_d = fall ? '0 : timer_q + 1'b1;
    end

    if (timeout) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      timer_d   = '0;
      error_o   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (fall) begin
            if (!bit_in) begin
              state_d   = ST_SHIFT;
              bit_cnt_d = '0;
            end else begin
              error_o = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (fall) begin
            shift_d = {bit_in, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (fall) begin
            parity_d = bit_in;
            state_d  = ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            if (bit_in && (^{shift_q, parity_q})) begin
              valid_o = 1'b1;
            end else begin
              error_o = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pulses are strobes in the edge cycle; the top registers them with the decoded outputs.
  assign data_o = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      timer_q     <= timer_d;
    end
  end

endmodule

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: frame reception plus make/break/extended decode for the synth KeyCode/Enable inputs.
module ps2_keycode_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       Clock,
  input  logic       btnCpuReset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] KeyCode,
  output logic       Enable,
  output logic       FrameValid,
  output logic       FrameError
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  logic [7:0] key_q, key_d;
  logic       en_q, en_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       valid_q, error_q;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (Clock),
    .rst_n     (btnCpuReset),
    .ps2_clk_i (PS2Clk),
    .ps2_data_i(PS2Data),
    .data_o    (rx_data),
    .valid_o   (rx_valid),
    .error_o   (rx_error)
  );

  always_comb begin
    key_d = key_q;
    en_d  = en_q;
    brk_d = brk_q;
    ext_d = ext_q;
    if (rx_valid) begin
      if (rx_data == BREAK_CODE) begin
        brk_d = 1'b1;
      end else if (rx_data == EXT_CODE) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        if (rx_data == key_q) begin
          en_d = 1'b0;
        end
        brk_d = 1'b0;
      end else begin
        key_d = rx_data;
        en_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      key_q   <= '0;
      en_q    <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      en_q    <= en_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      valid_q <= rx_valid;
      error_q <= rx_error;
    end
  end

  assign KeyCode    = key_q;
  assign Enable     = en_q;
  assign FrameValid = valid_q;
  assign FrameError = error_q;

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Randomized self-checking bench for ps2_keycode_receiver against a frame-level decode model.
module tb_ps2_keycode_receiver;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 300;
  localparam int unsigned H    = 24;

  logic       Clock = 1'b0;
  logic       btnCpuReset = 1'b0;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic [7:0] KeyCode;
  logic       Enable;
  logic       FrameValid;
  logic       FrameError;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt = 0, ecnt = 0, overlap = 0;
  logic [7:0] key_at_v = '0;
  logic       en_at_v  = 1'b0;

  logic [7:0] mkey = '0;
  logic       men = 1'b0, mbrk = 1'b0, mext = 1'b0;

  ps2_keycode_receiver #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clock      (Clock),
    .btnCpuReset(btnCpuReset),
    .PS2Clk     (PS2Clk),
    .PS2Data    (PS2Data),
    .KeyCode    (KeyCode),
    .Enable     (Enable),
    .FrameValid (FrameValid),
    .FrameError (FrameError)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (FrameValid) begin
      vcnt++;
      key_at_v = KeyCode;
      en_at_v  = Enable;
    end
    if (FrameError) ecnt++;
    if (FrameValid && FrameError) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic model_apply(input logic [7:0] c);
    if (c == 8'hF0) mbrk = 1'b1;
    else if (c == 8'hE0) mext = 1'b1;
    else if (mext) begin
      mext = 1'b0;
      mbrk = 1'b0;
    end else if (mbrk) begin
      if (c == mkey) men = 1'b0;
      mbrk = 1'b0;
    end else begin
      mkey = c;
      men  = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      PS2Data = bits[i];
      wait_cycles(H);
      PS2Clk = 1'b0;
      wait_cycles(H);
      PS2Clk = 1'b1;
    end
    PS2Data = 1'b1;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] code, input bit perr, input bit serr);
    int v0, e0;
    logic par;
    logic good;
    v0   = vcnt;
    e0   = ecnt;
    par  = ~(^code) ^ perr;
    good = !perr && !serr;
    send_bits({~serr, par, code, 1'b0}, 11);
    wait_cycles(20);
    if (good) model_apply(code);
    check({tag, ".valid_cnt"}, vcnt - v0, good ? 1 : 0);
    check({tag, ".error_cnt"}, ecnt - e0, good ? 0 : 1);
    check({tag, ".key"}, KeyCode, mkey);
    check({tag, ".en"}, Enable, men);
    if (good) check({tag, ".key_at_valid"}, {key_at_v, 7'd0, en_at_v}, {mkey, 7'd0, men});
  endtask

  logic [7:0] codes [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};

  initial begin
    int v0, e0;
    wait_cycles(3);
    check("rst.key", KeyCode, 8'h00);
    check("rst.en", Enable, 0);
    check("rst.pulses", {FrameValid, FrameError}, 2'b00);
    btnCpuReset = 1'b1;
    wait_cycles(10);

    send_frame("make_1c", 8'h1C, 0, 0);
    send_frame("make_1b", 8'h1B, 0, 0);
    send_frame("brk_f0a", 8'hF0, 0, 0);
    send_frame("brk_1c_other", 8'h1C, 0, 0);
    send_frame("brk_f0b", 8'hF0, 0, 0);
    send_frame("brk_1b_match", 8'h1B, 0, 0);

    send_frame("parity_err", 8'h1C, 1, 0);
    send_frame("after_par_23", 8'h23, 0, 0);
    send_frame("stop_err", 8'h2B, 0, 1);

    v0 = vcnt; e0 = ecnt;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    wait_cycles(TMO + 40);
    check("timeout.error_cnt", ecnt - e0, 1);
    check("timeout.valid_cnt", vcnt - v0, 0);
    check("timeout.key", KeyCode, mkey);
    send_frame("after_tmo_1c", 8'h1C, 0, 0);

    v0 = vcnt; e0 = ecnt;
    PS2Clk = 1'b0;
    wait_cycles(3);
    PS2Clk = 1'b1;
    wait_cycles(40);
    check("glitch.pulses", (vcnt - v0) + (ecnt - e0), 0);
    check("glitch.en", Enable, men);

    send_frame("ext_e0", 8'hE0, 0, 0);
    send_frame("ext_75", 8'h75, 0, 0);

    send_bits({1'b1, 1'b0, 8'h1B, 1'b0}, 4);
    btnCpuReset = 1'b0;
    wait_cycles(4);
    check("midrst.key", KeyCode, 8'h00);
    check("midrst.en", Enable, 0);
    check("midrst.pulses", {FrameValid, FrameError}, 2'b00);
    mkey = '0; men = 1'b0; mbrk = 1'b0; mext = 1'b0;
    btnCpuReset = 1'b1;
    wait_cycles(TMO + 40);
    send_frame("after_rst_1c", 8'h1C, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 9);
      c = codes[$urandom_range(0, 3)];
      if (r <= 3) send_frame("rnd_make", c, 0, 0);
      else if (r <= 5) send_frame("rnd_f0", 8'hF0, 0, 0);
      else if (r == 6) send_frame("rnd_e0", 8'hE0, 0, 0);
      else if (r == 7) send_frame("rnd_any", 8'($urandom_range(0, 255)), 0, 0);
      else if (r == 8) send_frame("rnd_perr", c, 1, 0);
      else send_frame("rnd_serr", c, 0, 1);
    end

    check("no_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
